// File: rtl/cache_control.sv
// Control FSM for a direct-mapped write-back L1 cache: hit/miss decode, array strobes,
// write-back/line-fill sequencing on the physical memory port, saturating perf counters.
module cache_control #(
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              hit,
    input  logic              dirty,
    input  logic              pmem_resp,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic              data_write,
    output logic              tag_write,
    output logic              valid_write,
    output logic              dirty_write,
    output logic              dirty_in,
    output logic              datain_sel,
    output logic              pmem_addr_sel,
    output logic [PERF_W-1:0] hit_count,
    output logic [PERF_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        S_CHECK = 2'd0,
        S_WB    = 2'd1,
        S_ALLOC = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PERF_W-1:0] hit_count_q, hit_count_d;
    logic [PERF_W-1:0] miss_count_q, miss_count_d;

    logic req;
    logic mem_resp_c, pmem_read_c, pmem_write_c, data_write_c, tag_write_c;
    logic valid_write_c, dirty_write_c, dirty_in_c, datain_sel_c, pmem_addr_sel_c;

    assign req = mem_read | mem_write;

    always_comb begin
        state_d         = state_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        mem_resp_c      = 1'b0;
        pmem_read_c     = 1'b0;
        pmem_write_c    = 1'b0;
        data_write_c    = 1'b0;
        tag_write_c     = 1'b0;
        valid_write_c   = 1'b0;
        dirty_write_c   = 1'b0;
        dirty_in_c      = 1'b0;
        datain_sel_c    = 1'b0;
        pmem_addr_sel_c = 1'b0;
        unique case (state_q)
            S_CHECK: begin
                if (req && hit) begin
                    mem_resp_c = 1'b1;
                    if (hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
                    // A simultaneous read+write is serviced as a write.
                    if (mem_write) begin
                        data_write_c  = 1'b1;
                        dirty_write_c = 1'b1;
                        dirty_in_c    = 1'b1;
                    end
                end else if (req) begin
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
                    state_d = dirty ? S_WB : S_ALLOC;
                end
            end
            S_WB: begin
                pmem_write_c    = 1'b1;
                pmem_addr_sel_c = 1'b1;
                if (pmem_resp) state_d = S_ALLOC;
            end
            S_ALLOC: begin
                pmem_read_c = 1'b1;
                if (pmem_resp) begin
                    data_write_c  = 1'b1;
                    tag_write_c   = 1'b1;
                    valid_write_c = 1'b1;
                    dirty_write_c = 1'b1;
                    datain_sel_c  = 1'b1;
                    state_d       = S_CHECK;
                end
            end
            default: state_d = S_CHECK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CHECK;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Outputs are gated by rst_n so that no strobe or request escapes while reset is held,
    // even when CPU inputs would otherwise produce a same-cycle response.
    assign mem_resp      = mem_resp_c      & rst_n;
    assign pmem_read     = pmem_read_c     & rst_n;
    assign pmem_write    = pmem_write_c    & rst_n;
    assign data_write    = data_write_c    & rst_n;
    assign tag_write     = tag_write_c     & rst_n;
    assign valid_write   = valid_write_c   & rst_n;
    assign dirty_write   = dirty_write_c   & rst_n;
    assign dirty_in      = dirty_in_c      & rst_n;
    assign datain_sel    = datain_sel_c    & rst_n;
    assign pmem_addr_sel = pmem_addr_sel_c & rst_n;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: queue-of-pending-memory-ops reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_cache_control;

    localparam int unsigned PW   = 4;
    localparam int          MAXC = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, dirty = 1'b0, pmem_resp = 1'b0;
    logic          mem_resp, pmem_read, pmem_write, data_write, tag_write, valid_write;
    logic          dirty_write, dirty_in, datain_sel, pmem_addr_sel;
    logic [PW-1:0] hit_count, miss_count;
    logic [9:0]    outv;

    int n_vec = 0;
    int n_err = 0;

    cache_control #(.PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .hit(hit), .dirty(dirty),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .data_write(data_write), .tag_write(tag_write),
        .valid_write(valid_write), .dirty_write(dirty_write), .dirty_in(dirty_in),
        .datain_sel(datain_sel), .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Bit order: mem_resp, pmem_read, pmem_write, data_write, tag_write, valid_write,
    //            dirty_write, dirty_in, datain_sel, pmem_addr_sel
    assign outv = {mem_resp, pmem_read, pmem_write, data_write, tag_write, valid_write,
                   dirty_write, dirty_in, datain_sel, pmem_addr_sel};

    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_RHIT  = 10'b1000000000;
    localparam logic [9:0] V_WHIT  = 10'b1001001100;
    localparam logic [9:0] V_WB    = 10'b0010000001;
    localparam logic [9:0] V_ALLOC = 10'b0100000000;
    localparam logic [9:0] V_FILL  = 10'b0101111010;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the list of memory operations still owed to the current miss.
    typedef enum {OP_WB, OP_FILL} op_e;
    op_e m_ops[$];
    int  m_hits = 0;
    int  m_miss = 0;

    function automatic logic [9:0] model_out();
        logic [9:0] e;
        e = V_IDLE;
        if (!rst_n) return e;
        if (m_ops.size() == 0) begin
            if ((mem_read || mem_write) && hit) e = mem_write ? V_WHIT : V_RHIT;
        end else if (m_ops[0] == OP_WB) begin
            e = V_WB;
        end else begin
            e = pmem_resp ? V_FILL : V_ALLOC;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ops.delete();
            m_hits = 0;
            m_miss = 0;
        end else if (m_ops.size() == 0) begin
            if ((mem_read || mem_write) && hit) begin
                m_hits = (m_hits >= MAXC) ? MAXC : m_hits + 1;
            end else if (mem_read || mem_write) begin
                m_miss = (m_miss >= MAXC) ? MAXC : m_miss + 1;
                if (dirty) m_ops.push_back(OP_WB);
                m_ops.push_back(OP_FILL);
            end
        end else if (pmem_resp) begin
            void'(m_ops.pop_front());
        end
    end

    always @(negedge clk) begin
        check("model_outputs", int'(outv), int'(model_out()));
        check("model_hit_count", int'(hit_count), m_hits);
        check("model_miss_count", int'(miss_count), m_miss);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("reset_outputs", int'(outv), int'(V_IDLE));
        check("reset_hit_count", int'(hit_count), 0);
        check("reset_miss_count", int'(miss_count), 0);
        cyc();
        rst_n = 1'b1;

        // 1: clean read miss, fill, re-check hit
        cyc();
        mem_read = 1'b1; hit = 1'b0; dirty = 1'b0;
        #2 check("t1_miss_cycle", int'(outv), int'(V_IDLE));
        cyc();
        #2 check("t1_alloc", int'(outv), int'(V_ALLOC));
        cyc();
        cyc();
        cyc();
        pmem_resp = 1'b1;
        #2 check("t1_fill", int'(outv), int'(V_FILL));
        cyc();
        pmem_resp = 1'b0; hit = 1'b1;
        #2 check("t1_recheck_resp", int'(outv), int'(V_RHIT));
        cyc();
        mem_read = 1'b0; hit = 1'b0;
        #2 check("t1_miss_count", int'(miss_count), 1);
        check("t1_hit_count", int'(hit_count), 1);

        // 2: write hit
        do_reset();
        cyc();
        mem_write = 1'b1; hit = 1'b1;
        #2 check("t2_write_hit", int'(outv), int'(V_WHIT));
        cyc();
        mem_write = 1'b0; hit = 1'b0;
        #2 check("t2_hit_count", int'(hit_count), 1);

        // 3: dirty miss, write-back then fill, never both requests
        do_reset();
        cyc();
        mem_read = 1'b1; dirty = 1'b1;
        cyc();
        dirty = 1'b0;
        #2 check("t3_wb_c1", int'(outv), int'(V_WB));
        cyc();
        #2 check("t3_wb_c2", int'(outv), int'(V_WB));
        pmem_resp = 1'b1;
        #1 check("t3_wb_resp", int'(outv), int'(V_WB));
        cyc();
        pmem_resp = 1'b0;
        #2 check("t3_alloc", int'(outv), int'(V_ALLOC));
        check("t3_no_overlap", int'(pmem_read & pmem_write), 0);
        cyc();
        pmem_resp = 1'b1;
        #2 check("t3_fill", int'(outv), int'(V_FILL));
        cyc();
        pmem_resp = 1'b0; hit = 1'b1;
        #2 check("t3_recheck", int'(outv), int'(V_RHIT));
        cyc();
        mem_read = 1'b0; hit = 1'b0;

        // 4: hit counter saturation
        do_reset();
        cyc();
        mem_read = 1'b1; hit = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        mem_read = 1'b0; hit = 1'b0;
        #2 check("t4_hit_sat", int'(hit_count), 15);
        check("t4_miss_zero", int'(miss_count), 0);

        // 5: asynchronous reset during write-back
        do_reset();
        cyc();
        mem_read = 1'b1; dirty = 1'b1;
        cyc();
        #2 check("t5_in_wb", int'(outv), int'(V_WB));
        rst_n = 1'b0;
        #1 check("t5_async_pmem_write", int'(pmem_write), 0);
        check("t5_async_miss_count", int'(miss_count), 0);
        cyc();
        dirty = 1'b0; hit = 1'b1;
        #2 check("t5_resp_gated", int'(mem_resp), 0);
        cyc();
        rst_n = 1'b1;
        #2 check("t5_post_reset_hit", int'(outv), int'(V_RHIT));
        cyc();
        mem_read = 1'b0; hit = 1'b0;

        // 6: request dropped during allocate
        do_reset();
        cyc();
        mem_read = 1'b1;
        cyc();
        #2 check("t6_alloc", int'(outv), int'(V_ALLOC));
        cyc();
        mem_read = 1'b0;
        #2 check("t6_alloc_held", int'(outv), int'(V_ALLOC));
        cyc();
        cyc();
        pmem_resp = 1'b1;
        #2 check("t6_fill", int'(outv), int'(V_FILL));
        cyc();
        pmem_resp = 1'b0;
        #2 check("t6_idle_after", int'(outv), int'(V_IDLE));
        cyc();
        #2 check("t6_counts", int'({hit_count, miss_count}), int'({4'd0, 4'd1}));

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
